// File: rtl/cfg_chain_loader.sv
// Host-side loader for the fabric's serial configuration chain: serializes 32-bit words MSB-first
// onto prog_in with a divided prog_clk, and reassembles the chain's shifted-out bits as readback.
module cfg_chain_loader #(
   parameter int unsigned CHAIN_LEN = 4096,
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned CNT_W     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        prog_in,
   output logic        prog_en,
   output logic        prog_clk,
   input  logic        prog_out,
   output logic [31:0] rb_data,
   output logic        rb_valid,
   output logic        busy,
   output logic        done
);

   localparam int unsigned     PH_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(CHAIN_LEN);

   typedef enum logic [2:0] {StIdle, StFetch, StLow, StHigh, StFlush, StFin} state_e;

   state_e           state_q, state_d;
   logic [PH_W-1:0]  phase_q, phase_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [5:0]       word_left_q, word_left_d;
   logic [31:0]      tx_q, tx_d;
   logic [31:0]      rb_sh_q, rb_sh_d;
   logic [5:0]       rb_cnt_q, rb_cnt_d;
   logic [31:0]      rb_data_q, rb_data_d;
   logic             rb_valid_q, rb_valid_d;
   logic             prog_in_q, prog_in_d;
   logic             prog_clk_q;
   logic             accept;
   logic             phase_end;
   logic             capture;

   assign accept    = (state_q == StFetch) && s_valid;
   assign phase_end = (phase_q == PH_LAST);
   // prog_out is sampled on the same clk edge that raises prog_clk, i.e. before the chain shifts.
   assign capture   = (state_q == StLow) && phase_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StFetch;
         end
         StFetch: begin
            if (s_valid) state_d = StLow;
         end
         StLow: begin
            if (phase_end) state_d = StHigh;
         end
         StHigh: begin
            if (phase_end) begin
               if (bit_cnt_q == BITS_LAST) begin
                  state_d = StFlush;
               end else if (word_left_q == 6'd0) begin
                  state_d = StFetch;
               end else begin
                  state_d = StLow;
               end
            end
         end
         StFlush: state_d = StFin;
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      phase_d     = '0;
      bit_cnt_d   = bit_cnt_q;
      word_left_d = word_left_q;
      tx_d        = tx_q;
      rb_sh_d     = rb_sh_q;
      rb_cnt_d    = rb_cnt_q;
      rb_data_d   = rb_data_q;
      rb_valid_d  = 1'b0;
      prog_in_d   = prog_in_q;

      if (state_d == state_q && (state_q == StLow || state_q == StHigh)) begin
         phase_d = phase_q + PH_W'(1);
      end

      if (state_q == StIdle) begin
         bit_cnt_d = '0;
         rb_sh_d   = '0;
         rb_cnt_d  = '0;
      end

      if (accept) begin
         tx_d        = s_data;
         word_left_d = 6'd32;
      end else if (state_q == StHigh && phase_end) begin
         tx_d = {tx_q[30:0], 1'b0};
      end

      if (capture) begin
         bit_cnt_d   = bit_cnt_q + CNT_W'(1);
         word_left_d = word_left_q - 6'd1;
         rb_sh_d     = {rb_sh_q[30:0], prog_out};
         if (rb_cnt_q == 6'd31) begin
            rb_cnt_d   = 6'd0;
            rb_data_d  = {rb_sh_q[30:0], prog_out};
            rb_valid_d = 1'b1;
         end else begin
            rb_cnt_d = rb_cnt_q + 6'd1;
         end
      end

      // A partial last readback word is left-aligned so the first-out bit stays at bit 31.
      if (state_q == StHigh && state_d == StFlush && rb_cnt_q != 6'd0) begin
         rb_data_d  = rb_sh_q << (6'd32 - rb_cnt_q);
         rb_valid_d = 1'b1;
      end

      // prog_in only moves on entry to the low phase, so it is stable across every rise.
      if (state_d == StLow && state_q != StLow) begin
         prog_in_d = tx_d[31];
      end else if (state_d == StIdle || state_d == StFin) begin
         prog_in_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q     <= '0;
         bit_cnt_q   <= '0;
         word_left_q <= '0;
         tx_q        <= '0;
         rb_sh_q     <= '0;
         rb_cnt_q    <= '0;
         rb_data_q   <= '0;
         rb_valid_q  <= 1'b0;
         prog_in_q   <= 1'b0;
         prog_clk_q  <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         bit_cnt_q   <= bit_cnt_d;
         word_left_q <= word_left_d;
         tx_q        <= tx_d;
         rb_sh_q     <= rb_sh_d;
         rb_cnt_q    <= rb_cnt_d;
         rb_data_q   <= rb_data_d;
         rb_valid_q  <= rb_valid_d;
         prog_in_q   <= prog_in_d;
         prog_clk_q  <= (state_d == StHigh);
      end
   end

   always_comb begin
      s_ready = 1'b0;
      prog_en = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         StFetch: begin
            s_ready = 1'b1;
            prog_en = 1'b1;
            busy    = 1'b1;
         end
         StLow, StHigh, StFlush: begin
            prog_en = 1'b1;
            busy    = 1'b1;
         end
         StFin:   done = 1'b1;
         default: ;
      endcase
   end

   assign prog_in  = prog_in_q;
   assign prog_clk = prog_clk_q;
   assign rb_data  = rb_data_q;
   assign rb_valid = rb_valid_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: three configurations, each driving a behavioural chain model
// clocked by prog_clk, checked from a table of load vectors plus reset/start corner sequences.
module tb_cfg_chain_loader;

   typedef struct {
      int          idx;
      logic [63:0] pre;
      logic [31:0] w0;
      logic [31:0] w1;
      int          words;
      int          stall;
      int          poke;
      logic [31:0] rb0;
      logic [31:0] rb1;
      int          nrb;
      logic [63:0] chain;
      int          nrise;
      int          gapchk;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  start_v, s_valid_v, s_ready_v, prog_in_v, prog_en_v, prog_clk_v, prog_out_v;
   logic [2:0]  rb_valid_v, busy_v, done_v;
   logic [31:0] s_data_v [3];
   logic [31:0] rb_data_v [3];

   logic [2:0]  ld_v;
   logic [63:0] pre_v;
   logic [39:0] chain0;
   logic [63:0] chain1;
   logic [31:0] chain2;

   int checks = 0;
   int errors = 0;
   int tmo = 0;

   always #5 clk = ~clk;

   cfg_chain_loader #(.CHAIN_LEN(40), .CLK_DIV(2), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .s_data(s_data_v[0]), .s_valid(s_valid_v[0]),
      .s_ready(s_ready_v[0]), .prog_in(prog_in_v[0]), .prog_en(prog_en_v[0]),
      .prog_clk(prog_clk_v[0]), .prog_out(prog_out_v[0]), .rb_data(rb_data_v[0]),
      .rb_valid(rb_valid_v[0]), .busy(busy_v[0]), .done(done_v[0])
   );

   cfg_chain_loader #(.CHAIN_LEN(64), .CLK_DIV(1), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .s_data(s_data_v[1]), .s_valid(s_valid_v[1]),
      .s_ready(s_ready_v[1]), .prog_in(prog_in_v[1]), .prog_en(prog_en_v[1]),
      .prog_clk(prog_clk_v[1]), .prog_out(prog_out_v[1]), .rb_data(rb_data_v[1]),
      .rb_valid(rb_valid_v[1]), .busy(busy_v[1]), .done(done_v[1])
   );

   cfg_chain_loader #(.CHAIN_LEN(32), .CLK_DIV(3), .CNT_W(16)) u2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .s_data(s_data_v[2]), .s_valid(s_valid_v[2]),
      .s_ready(s_ready_v[2]), .prog_in(prog_in_v[2]), .prog_en(prog_en_v[2]),
      .prog_clk(prog_clk_v[2]), .prog_out(prog_out_v[2]), .rb_data(rb_data_v[2]),
      .rb_valid(rb_valid_v[2]), .busy(busy_v[2]), .done(done_v[2])
   );

   // Chain models: shift prog_in in at bit 0 on each prog_clk rise, tail drives prog_out.
   always @(posedge prog_clk_v[0] or posedge ld_v[0])
      if (ld_v[0]) chain0 <= pre_v[39:0];
      else         chain0 <= {chain0[38:0], prog_in_v[0]};
   always @(posedge prog_clk_v[1] or posedge ld_v[1])
      if (ld_v[1]) chain1 <= pre_v;
      else         chain1 <= {chain1[62:0], prog_in_v[1]};
   always @(posedge prog_clk_v[2] or posedge ld_v[2])
      if (ld_v[2]) chain2 <= pre_v[31:0];
      else         chain2 <= {chain2[30:0], prog_in_v[2]};

   assign prog_out_v[0] = chain0[39];
   assign prog_out_v[1] = chain1[63];
   assign prog_out_v[2] = chain2[31];

   function automatic int div_of(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 3);
   endfunction

   function automatic logic [63:0] chain_of(input int i);
      if (i == 0) return {24'h0, chain0};
      if (i == 1) return chain1;
      return {32'h0, chain2};
   endfunction

   int          cyc = 0;
   int          rises [3] = '{default: 0};
   int          acc [3] = '{default: 0};
   int          rb_n [3] = '{default: 0};
   int          done_n [3] = '{default: 0};
   int          viol [3] = '{default: 0};
   int          stab [3] = '{default: 0};
   int          last_rise [3] = '{default: 0};
   int          acc_cyc [3] = '{default: 0};
   int          done_cyc [3] = '{default: 0};
   int          gaps [3][256];
   logic [31:0] rb_got [3][64];
   logic [2:0]  pclk_prev = '0;
   logic [2:0]  pin_prev = '0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 3; i++) begin
         pclk_prev[i] <= prog_clk_v[i];
         pin_prev[i]  <= prog_in_v[i];
         if (prog_in_v[i] != pin_prev[i]) begin
            stab[i] <= 0;
            if (prog_clk_v[i]) viol[i] <= viol[i] + 1;
         end else begin
            stab[i] <= stab[i] + 1;
         end
         if (prog_clk_v[i] && !pclk_prev[i]) begin
            rises[i]                 <= rises[i] + 1;
            last_rise[i]             <= cyc;
            gaps[i][rises[i] % 256]  <= cyc - last_rise[i];
            if (stab[i] + 1 < div_of(i)) viol[i] <= viol[i] + 1;
         end
         if (s_valid_v[i] && s_ready_v[i]) begin
            acc[i]     <= acc[i] + 1;
            acc_cyc[i] <= cyc;
         end
         if (rb_valid_v[i]) begin
            rb_got[i][rb_n[i] % 64] <= rb_data_v[i];
            rb_n[i]                 <= rb_n[i] + 1;
         end
         if (done_v[i]) begin
            done_n[i]   <= done_n[i] + 1;
            done_cyc[i] <= cyc;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic wait_acc(input int i, input int target);
      int n = 0;
      while (acc[i] < target && n < 3000) begin
         @(posedge clk);
         n++;
      end
      if (acc[i] < target) tmo++;
   endtask

   task automatic wait_done(input int i, input int target);
      int n = 0;
      while (done_n[i] < target && n < 3000) begin
         @(posedge clk);
         n++;
      end
      if (done_n[i] < target) tmo++;
   endtask

   task automatic pulse_start(input int i);
      @(posedge clk);
      #1 start_v[i] = 1'b1;
      @(posedge clk);
      #1 start_v[i] = 1'b0;
   endtask

   task automatic run_load(input vec_t v, input int vn);
      int i, r0, a0, n0, d0, v0, t0, st_bad, gap_bad, d, exp_gap, b_last;
      i = v.idx;
      d = div_of(i);
      r0 = rises[i]; a0 = acc[i]; n0 = rb_n[i]; d0 = done_n[i]; v0 = viol[i]; t0 = tmo;
      st_bad = 0;
      gap_bad = 0;
      pre_v = v.pre;
      ld_v[i] = 1'b1;
      #1 ld_v[i] = 1'b0;
      s_data_v[i]  = v.w0;
      s_valid_v[i] = 1'b1;
      pulse_start(i);
      wait_acc(i, a0 + 1);
      #1;
      if (v.words > 1) begin
         s_data_v[i] = v.w1;
         if (v.poke != 0) pulse_start(i);
         if (v.stall != 0) begin
            s_valid_v[i] = 1'b0;
            for (int n = 0; n < 3000 && !s_ready_v[i]; n++) @(negedge clk);
            for (int n = 0; n < v.stall; n++) begin
               if (prog_clk_v[i] !== 1'b0 || prog_en_v[i] !== 1'b1) st_bad++;
               @(negedge clk);
            end
            @(posedge clk);
            #1 s_valid_v[i] = 1'b1;
         end
         wait_acc(i, a0 + 2);
         #1;
      end
      // Junk word stays offered after the last one; it must never be taken.
      s_data_v[i] = 32'hBAD0_BAD0;
      wait_done(i, d0 + 1);
      s_valid_v[i] = 1'b0;
      repeat (6) @(posedge clk);

      check($sformatf("v%0d timeout", vn), 64'(tmo - t0), 64'd0);
      check($sformatf("v%0d rises", vn), 64'(rises[i] - r0), 64'(v.nrise));
      check($sformatf("v%0d words", vn), 64'(acc[i] - a0), 64'(v.words));
      check($sformatf("v%0d done_cnt", vn), 64'(done_n[i] - d0), 64'd1);
      check($sformatf("v%0d rb_cnt", vn), 64'(rb_n[i] - n0), 64'(v.nrb));
      check($sformatf("v%0d rb0", vn), 64'(rb_got[i][n0 % 64]), 64'(v.rb0));
      if (v.nrb > 1) check($sformatf("v%0d rb1", vn), 64'(rb_got[i][(n0 + 1) % 64]), 64'(v.rb1));
      check($sformatf("v%0d chain", vn), chain_of(i), v.chain);
      check($sformatf("v%0d prog_in_stable", vn), 64'(viol[i] - v0), 64'd0);
      if (v.stall != 0) check($sformatf("v%0d stall_hold", vn), 64'(st_bad), 64'd0);
      if (v.gapchk != 0) begin
         // One extra FETCH cycle sits between the last rise of a word and the next low phase.
         for (int k = 1; k < v.nrise; k++) begin
            exp_gap = 2 * d + ((k % 32 == 0) ? 1 : 0);
            if (gaps[i][(r0 + k) % 256] != exp_gap) gap_bad++;
         end
         check($sformatf("v%0d rise_gaps", vn), 64'(gap_bad), 64'd0);
         b_last = v.nrise - 32 * (v.words - 1);
         check($sformatf("v%0d done_lat", vn), 64'(done_cyc[i] - acc_cyc[i]),
               64'(2 * d * b_last + 2));
      end
   endtask

   vec_t tbl [5];

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, d0, bsy;
      rst = 1'b1;
      start_v = '0;
      s_valid_v = '0;
      ld_v = '0;
      pre_v = '0;
      for (int i = 0; i < 3; i++) s_data_v[i] = '0;

      tbl[0] = '{0, 64'h12_3456_789A, 32'hA5A5_A5A5, 32'hFF00_0000, 2, 0, 0,
                 32'h1234_5678, 32'h9A00_0000, 2, 64'hA5_A5A5_A5FF, 40, 1};
      tbl[1] = '{0, 64'h12_3456_789A, 32'hA5A5_A5A5, 32'hFF00_0000, 2, 10, 0,
                 32'h1234_5678, 32'h9A00_0000, 2, 64'hA5_A5A5_A5FF, 40, 0};
      tbl[2] = '{0, 64'hFF_0000_00C3, 32'h0F0F_3C3C, 32'h8000_0000, 2, 0, 1,
                 32'hFF00_0000, 32'hC300_0000, 2, 64'h0F_0F3C_3C80, 40, 1};
      tbl[3] = '{1, 64'h0, 32'hDEAD_BEEF, 32'h0123_CAFE, 2, 0, 0,
                 32'h0, 32'h0, 2, 64'hDEAD_BEEF_0123_CAFE, 64, 1};
      tbl[4] = '{2, 64'hCAFE_F00D, 32'h1357_9BDF, 32'h0, 1, 0, 0,
                 32'hCAFE_F00D, 32'h0, 1, 64'h1357_9BDF, 32, 1};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst%0d prog_in", i), 64'(prog_in_v[i]), 64'd0);
         check($sformatf("rst%0d prog_en", i), 64'(prog_en_v[i]), 64'd0);
         check($sformatf("rst%0d prog_clk", i), 64'(prog_clk_v[i]), 64'd0);
         check($sformatf("rst%0d s_ready", i), 64'(s_ready_v[i]), 64'd0);
         check($sformatf("rst%0d rb_data", i), 64'(rb_data_v[i]), 64'd0);
         check($sformatf("rst%0d rb_valid", i), 64'(rb_valid_v[i]), 64'd0);
         check($sformatf("rst%0d busy", i), 64'(busy_v[i]), 64'd0);
         check($sformatf("rst%0d done", i), 64'(done_v[i]), 64'd0);
      end

      for (int n = 0; n < 5; n++) run_load(tbl[n], n);

      // Reset one cycle after the 17th prog_clk rise aborts the load without a done pulse.
      r0 = rises[0];
      d0 = done_n[0];
      pre_v = 64'h12_3456_789A;
      ld_v[0] = 1'b1;
      #1 ld_v[0] = 1'b0;
      s_data_v[0] = 32'hA5A5_A5A5;
      s_valid_v[0] = 1'b1;
      pulse_start(0);
      for (int n = 0; n < 3000 && rises[0] - r0 < 17; n++) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      s_valid_v[0] = 1'b0;
      @(negedge clk);
      check("abort prog_en", 64'(prog_en_v[0]), 64'd0);
      check("abort prog_clk", 64'(prog_clk_v[0]), 64'd0);
      check("abort busy", 64'(busy_v[0]), 64'd0);
      check("abort s_ready", 64'(s_ready_v[0]), 64'd0);
      repeat (30) @(posedge clk);
      check("abort rises", 64'(rises[0] - r0), 64'd17);
      check("abort no_done", 64'(done_n[0] - d0), 64'd0);

      run_load(tbl[0], 5);

      // start together with rst: rst wins.
      d0 = done_n[0];
      bsy = 0;
      @(posedge clk);
      #1 begin
         start_v[0] = 1'b1;
         rst = 1'b1;
      end
      @(posedge clk);
      #1 begin
         start_v[0] = 1'b0;
         rst = 1'b0;
      end
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (busy_v[0] || s_ready_v[0] || prog_en_v[0]) bsy++;
      end
      check("start_rst busy", 64'(bsy), 64'd0);
      check("start_rst no_done", 64'(done_n[0] - d0), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
